// File: rtl/wiscsc15_mc_seq.sv
// Multi-cycle control sequencer for the WISC-SC15 datapath.
// A six-state FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) that drives the memory, IR, PC and
// register-file strobes. Every output is decoded from the current state and the opcode
// latched in DECODE, so changes on the opcode input after DECODE have no effect.
module wiscsc15_mc_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       rf_w,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic [2:0] state
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [3:0] OpLw   = 4'b1000;
  localparam logic [3:0] OpSw   = 4'b1001;
  localparam logic [3:0] OpLhb  = 4'b1010;
  localparam logic [3:0] OpLlb  = 4'b1011;
  localparam logic [3:0] OpBr   = 4'b1100;
  localparam logic [3:0] OpCall = 4'b1101;
  localparam logic [3:0] OpRet  = 4'b1110;
  localparam logic [3:0] OpHlt  = 4'b1111;

  logic [2:0] r_state;
  logic [3:0] r_op_q;
  logic [2:0] w_next;

  assign state = r_state;

  // Next-state and strobe decode; reset masks every strobe in the same cycle.
  always_comb begin
    w_next       = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    rf_w         = 1'b0;
    wb_sel       = 2'b00;
    halted       = 1'b0;

    case (r_state)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_load = 1'b1;
          w_next  = StDecode;
        end
      end
      StDecode: begin
        w_next = (opcode == OpHlt) ? StHalt : StExec;
      end
      StExec: begin
        if (!r_op_q[3] || r_op_q == OpLhb || r_op_q == OpLlb) begin
          w_next = StWb;
        end else if (r_op_q == OpLw || r_op_q == OpSw || r_op_q == OpCall ||
                     r_op_q == OpRet) begin
          w_next = StMem;
        end else if (r_op_q == OpBr) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? 2'b01 : 2'b00;
          w_next   = StFetch;
        end else begin
          w_next = StFetch;
        end
      end
      StMem: begin
        // Address source and write strobe depend only on op_q, so they hold steady
        // for as long as the request waits on mem_rdy.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (r_op_q == OpSw) || (r_op_q == OpCall);
        if (mem_rdy) begin
          w_next = StFetch;
          case (r_op_q)
            OpLw: w_next = StWb;
            OpSw: pc_write = 1'b1;
            OpCall: begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
              rf_w     = 1'b1;
              wb_sel   = 2'b11;
            end
            OpRet: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
              rf_w     = 1'b1;
              wb_sel   = 2'b11;
            end
            default: ;
          endcase
        end
      end
      StWb: begin
        rf_w     = 1'b1;
        pc_write = 1'b1;
        case (r_op_q)
          OpLw:    wb_sel = 2'b00;
          OpLhb:   wb_sel = 2'b01;
          OpLlb:   wb_sel = 2'b10;
          default: wb_sel = 2'b11;
        endcase
        w_next = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        w_next = StFetch;
      end
    endcase

    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      rf_w         = 1'b0;
      wb_sel       = 2'b00;
      halted       = 1'b0;
    end
  end

  // State and latched-opcode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFetch;
      r_op_q  <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (r_state == StDecode) begin
        r_op_q <= opcode;
      end
    end
  end

endmodule
